// File: rtl/rcv_pkg.sv
// Shared constants, FSM state type and CRC-8 step function for the receive
// frame controller.
package rcv_pkg;

  localparam logic [7:0] FTYPE_DATA     = 8'h30;
  localparam logic [7:0] FTYPE_DATA_ACK = 8'h32;
  localparam logic [7:0] FTYPE_ACK      = 8'h33;
  localparam logic [7:0] FCS_FIXED      = 8'h55;
  localparam logic [7:0] CRC8_POLY      = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    SRC,
    TYPE,
    BODY,
    DROP,
    COMMIT
  } rcv_state_t;

  // One byte of MSB-first CRC-8, no reflection, no final xor.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rcv_crc8.sv
// Byte-serial CRC-8 accumulator. clr restarts the sum; clr together with enb
// starts a new sum with data as the first byte.
module rcv_crc8
  import rcv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enb,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // Accumulate one byte per enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= '0;
    end else if (enb) begin
      crc <= crc8_step(clr ? 8'h00 : crc, data);
    end else if (clr) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/rcv_frame_ctl.sv
// Receive frame controller: parses dest/src/ftype/payload/FCS, filters on
// address, checks the FCS and commits good payloads into a read buffer.
// Build option: RCV_CRC_CHECK_EN selects a CRC-8 FCS instead of the fixed 8'h55.
module rcv_frame_ctl
  import rcv_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter logic [7:0]  BCAST_ADDR = 8'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mac,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eof,
  input  logic       rx_err,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  output logic       ack_needed,
  output logic [7:0] ack_addr,
  input  logic       ack_done,
  output logic       ack_received,
  output logic [7:0] rerrcnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  rcv_state_t    state, state_next;
  logic [7:0]    dest_q, src_q, ftype_q;
  logic          body_any;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;

  logic full, for_me, dest_ok, ftype_known, fcs_good;
  logic lat_dest, lat_src, lat_ftype, wr_en;
  logic err_inc, rollback, do_commit, set_ack, pulse_ackrx;

  // One slot stays free so a full buffer never aliases an empty one.
  assign full        = (wr_ptr[AW-1:0] + AW'(1)) == rd_ptr[AW-1:0];
  assign for_me      = (dest_q == mac);
  assign dest_ok     = for_me || (dest_q == BCAST_ADDR);
  assign ftype_known = (rx_data == FTYPE_DATA) || (rx_data == FTYPE_DATA_ACK) ||
                       (rx_data == FTYPE_ACK);
  assign rd_empty    = (rd_ptr == cm_ptr);

`ifdef RCV_CRC_CHECK_EN
  logic [7:0] crc_q;
  logic       crc_clr, crc_enb;

  assign crc_clr = lat_dest;
  assign crc_enb = lat_dest | lat_src | lat_ftype | wr_en;

  rcv_crc8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .enb  (crc_enb),
    .data (rx_data),
    .crc  (crc_q)
  );

  // The FCS byte is folded into the sum too; a matching FCS leaves a zero remainder.
  assign fcs_good = (crc_q == 8'h00);
`else
  logic [7:0] last_byte;

  // Remember the most recent body byte; at COMMIT it is the FCS.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte <= '0;
    end else if (wr_en) begin
      last_byte <= rx_data;
    end
  end

  assign fcs_good = (last_byte == FCS_FIXED);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a byte in the same cycle as eof is consumed first.
  always_comb begin
    state_next = state;
    if (state != IDLE && rx_err) begin
      state_next = rx_eof ? IDLE : DROP;
    end else begin
      case (state)
        IDLE:   if (rx_valid && !rx_eof) state_next = SRC;
        SRC:    if (rx_eof) state_next = IDLE;
                else if (rx_valid) state_next = TYPE;
        TYPE:   if (rx_valid) begin
                  if (!dest_ok || !ftype_known) state_next = rx_eof ? IDLE : DROP;
                  else                          state_next = rx_eof ? COMMIT : BODY;
                end else if (rx_eof) begin
                  state_next = IDLE;
                end
        BODY:   if (rx_valid && full) state_next = rx_eof ? IDLE : DROP;
                else if (rx_eof)      state_next = COMMIT;
        DROP:   if (rx_eof) state_next = IDLE;
        COMMIT: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-state datapath controls.
  always_comb begin
    lat_dest    = 1'b0;
    lat_src     = 1'b0;
    lat_ftype   = 1'b0;
    wr_en       = 1'b0;
    err_inc     = 1'b0;
    rollback    = 1'b0;
    do_commit   = 1'b0;
    set_ack     = 1'b0;
    pulse_ackrx = 1'b0;
    if (state != IDLE && rx_err) begin
      err_inc  = 1'b1;
      rollback = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          lat_dest = rx_valid;
          err_inc  = rx_valid && rx_eof;
        end
        SRC: begin
          lat_src = rx_valid;
          err_inc = rx_eof;
        end
        TYPE: begin
          lat_ftype = rx_valid;
          if (rx_valid) err_inc = dest_ok && !ftype_known;
          else          err_inc = rx_eof;
        end
        BODY: begin
          if (rx_valid && full) begin
            err_inc  = 1'b1;
            rollback = 1'b1;
          end else begin
            wr_en = rx_valid;
          end
        end
        COMMIT: begin
          if (!body_any || !fcs_good) begin
            err_inc  = 1'b1;
            rollback = 1'b1;
          end else begin
            case (ftype_q)
              FTYPE_DATA:     do_commit = 1'b1;
              FTYPE_DATA_ACK: begin
                do_commit = 1'b1;
                set_ack   = for_me;
              end
              FTYPE_ACK: begin
                rollback    = 1'b1;
                pulse_ackrx = for_me;
              end
              default: rollback = 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Header field capture and body-byte presence flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q   <= '0;
      src_q    <= '0;
      ftype_q  <= '0;
      body_any <= 1'b0;
    end else begin
      if (lat_dest)  dest_q <= rx_data;
      if (lat_src)   src_q  <= rx_data;
      if (lat_ftype) begin
        ftype_q  <= rx_data;
        body_any <= 1'b0;
      end
      if (wr_en) body_any <= 1'b1;
    end
  end

  // Buffer pointers; commit drops the trailing FCS byte from both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= cm_ptr;
      end else if (do_commit) begin
        wr_ptr <= wr_ptr - PW'(1);
        cm_ptr <= wr_ptr - PW'(1);
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en && !rd_empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Payload RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en && !rd_empty) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  // ACK request/received handshakes; a new request beats a same-cycle ack_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_needed   <= 1'b0;
      ack_addr     <= '0;
      ack_received <= 1'b0;
    end else begin
      ack_received <= pulse_ackrx;
      if (set_ack) begin
        ack_needed <= 1'b1;
        ack_addr   <= src_q;
      end else if (ack_done) begin
        ack_needed <= 1'b0;
      end
    end
  end

  // Saturating receive error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rerrcnt <= '0;
    end else if (err_inc && rerrcnt != 8'hFF) begin
      rerrcnt <= rerrcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rcv_frame_ctl.sv
// Directed bench for rcv_frame_ctl (fixed-FCS build, 16-byte buffer).
module tb_rcv_frame_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mac = 8'h41;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_eof = 1'b0;
  logic       rx_err = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       ack_needed;
  logic [7:0] ack_addr;
  logic       ack_done = 1'b0;
  logic       ack_received;
  logic [7:0] rerrcnt;

  int tests = 0;
  int failed = 0;
  int ack_rx_cnt = 0;

  rcv_frame_ctl #(.DEPTH(16), .BCAST_ADDR(8'h2A)) dut (
    .clk          (clk),
    .rst          (rst),
    .mac          (mac),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_eof       (rx_eof),
    .rx_err       (rx_err),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .ack_needed   (ack_needed),
    .ack_addr     (ack_addr),
    .ack_done     (ack_done),
    .ack_received (ack_received),
    .rerrcnt      (rerrcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ack_received) ack_rx_cnt++;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task send_bytes(input logic [8*16-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = b[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task send_eof;
    rx_eof = 1'b1;
    tick();
    rx_eof = 1'b0;
  endtask

  task frame(input logic [8*16-1:0] b, input int n);
    send_bytes(b, n);
    send_eof();
    tick();
  endtask

  task pop;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL reset_rd_empty: got %b want 1", rd_empty); end
    tests++; if (rd_data !== 8'h00) begin failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL reset_ack_needed: got %b want 0", ack_needed); end
    tests++; if (ack_addr !== 8'h00) begin failed++; $display("FAIL reset_ack_addr: got %h want 00", ack_addr); end
    tests++; if (ack_received !== 1'b0) begin failed++; $display("FAIL reset_ack_received: got %b want 0", ack_received); end
    tests++; if (rerrcnt !== 8'h00) begin failed++; $display("FAIL reset_rerrcnt: got %h want 00", rerrcnt); end
  endtask

  task test_data_noack;
    int c0;
    c0 = ack_rx_cnt;
    send_bytes({8'h41, 8'h42, 8'h30, 8'h48, 8'h49, 8'h55}, 6);
    send_eof();
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL d30_empty_in_commit: got %b want 1", rd_empty); end
    tick();
    tests++; if (rd_empty !== 1'b0) begin failed++; $display("FAIL d30_empty_after_commit: got %b want 0", rd_empty); end
    pop();
    tests++; if (rd_data !== 8'h48) begin failed++; $display("FAIL d30_byte0: got %h want 48", rd_data); end
    pop();
    tests++; if (rd_data !== 8'h49) begin failed++; $display("FAIL d30_byte1: got %h want 49", rd_data); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL d30_drained: got %b want 1", rd_empty); end
    tests++; if (rerrcnt !== 8'd0) begin failed++; $display("FAIL d30_rerrcnt: got %0d want 0", rerrcnt); end
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL d30_ack_needed: got %b want 0", ack_needed); end
    tests++; if (ack_rx_cnt !== c0) begin failed++; $display("FAIL d30_ack_rx: got %0d want %0d", ack_rx_cnt, c0); end
  endtask

  task test_data_ack;
    frame({8'h41, 8'h42, 8'h32, 8'h58, 8'h55}, 5);
    tests++; if (ack_needed !== 1'b1) begin failed++; $display("FAIL d32_ack_needed: got %b want 1", ack_needed); end
    tests++; if (ack_addr !== 8'h42) begin failed++; $display("FAIL d32_ack_addr: got %h want 42", ack_addr); end
    tick(); tick(); tick();
    tests++; if (ack_needed !== 1'b1) begin failed++; $display("FAIL d32_ack_held: got %b want 1", ack_needed); end
    pop();
    tests++; if (rd_data !== 8'h58) begin failed++; $display("FAIL d32_byte: got %h want 58", rd_data); end
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL d32_ack_cleared: got %b want 0", ack_needed); end
  endtask

  task test_bcast_and_filter;
    frame({8'h2A, 8'h43, 8'h32, 8'h01, 8'h55}, 5);
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL bcast_no_ack: got %b want 0", ack_needed); end
    tests++; if (rd_empty !== 1'b0) begin failed++; $display("FAIL bcast_committed: got %b want 0", rd_empty); end
    pop();
    tests++; if (rd_data !== 8'h01) begin failed++; $display("FAIL bcast_byte: got %h want 01", rd_data); end
    frame({8'h44, 8'h42, 8'h30, 8'h01, 8'h55}, 5);
    tick();
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL filter_empty: got %b want 1", rd_empty); end
    tests++; if (rerrcnt !== 8'd0) begin failed++; $display("FAIL filter_rerrcnt: got %0d want 0", rerrcnt); end
  endtask

  task test_ack_rx;
    int c0;
    c0 = ack_rx_cnt;
    send_bytes({8'h41, 8'h42, 8'h33, 8'h55}, 4);
    send_eof();
    tick();
    tests++; if (ack_received !== 1'b1) begin failed++; $display("FAIL ackrx_pulse: got %b want 1", ack_received); end
    tick();
    tests++; if (ack_received !== 1'b0) begin failed++; $display("FAIL ackrx_pulse_end: got %b want 0", ack_received); end
    tick();
    tests++; if (ack_rx_cnt - c0 !== 1) begin failed++; $display("FAIL ackrx_count: got %0d want 1", ack_rx_cnt - c0); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL ackrx_empty: got %b want 1", rd_empty); end
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL ackrx_no_ack: got %b want 0", ack_needed); end
  endtask

  task test_ack_overwrite;
    frame({8'h41, 8'h42, 8'h32, 8'h11, 8'h55}, 5);
    frame({8'h41, 8'h47, 8'h32, 8'h12, 8'h55}, 5);
    tests++; if (ack_addr !== 8'h47) begin failed++; $display("FAIL ackow_addr: got %h want 47", ack_addr); end
    send_bytes({8'h41, 8'h49, 8'h32, 8'h13, 8'h55}, 5);
    send_eof();
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
    tests++; if (ack_needed !== 1'b1) begin failed++; $display("FAIL ackow_same_cycle: got %b want 1", ack_needed); end
    tests++; if (ack_addr !== 8'h49) begin failed++; $display("FAIL ackow_same_cycle_addr: got %h want 49", ack_addr); end
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL ackow_clear: got %b want 0", ack_needed); end
    pop();
    tests++; if (rd_data !== 8'h11) begin failed++; $display("FAIL ackow_b0: got %h want 11", rd_data); end
    pop();
    tests++; if (rd_data !== 8'h12) begin failed++; $display("FAIL ackow_b1: got %h want 12", rd_data); end
    pop();
    tests++; if (rd_data !== 8'h13) begin failed++; $display("FAIL ackow_b2: got %h want 13", rd_data); end
  endtask

  task test_errors;
    frame({8'h41, 8'h42, 8'h30, 8'h48, 8'h66}, 5);
    tests++; if (rerrcnt !== 8'd1) begin failed++; $display("FAIL err_fcs1: got %0d want 1", rerrcnt); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL err_fcs1_empty: got %b want 1", rd_empty); end
    frame({8'h41, 8'h42, 8'h30, 8'h48, 8'h66}, 5);
    tests++; if (rerrcnt !== 8'd2) begin failed++; $display("FAIL err_fcs2: got %0d want 2", rerrcnt); end
    send_bytes({8'h41, 8'h42, 8'h30, 8'h48}, 4);
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    send_bytes({8'h49, 8'h55}, 2);
    send_eof();
    tick();
    tests++; if (rerrcnt !== 8'd3) begin failed++; $display("FAIL err_rxerr: got %0d want 3", rerrcnt); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL err_rxerr_empty: got %b want 1", rd_empty); end
    frame({8'h41, 8'h42, 8'h30, 8'h77, 8'h55}, 5);
    pop();
    tests++; if (rd_data !== 8'h77) begin failed++; $display("FAIL err_rollback_data: got %h want 77", rd_data); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL err_rollback_len: got %b want 1", rd_empty); end
    frame({8'h41, 8'h42}, 2);
    tests++; if (rerrcnt !== 8'd4) begin failed++; $display("FAIL err_runt_hdr: got %0d want 4", rerrcnt); end
    frame({8'h41, 8'h42, 8'h31, 8'h48, 8'h55}, 5);
    tests++; if (rerrcnt !== 8'd5) begin failed++; $display("FAIL err_ftype: got %0d want 5", rerrcnt); end
    frame({8'h41, 8'h42, 8'h30}, 3);
    tests++; if (rerrcnt !== 8'd6) begin failed++; $display("FAIL err_runt_body: got %0d want 6", rerrcnt); end
    frame({8'h44, 8'h42, 8'h31, 8'h48, 8'h55}, 5);
    tests++; if (rerrcnt !== 8'd6) begin failed++; $display("FAIL err_mismatch_silent: got %0d want 6", rerrcnt); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL err_all_empty: got %b want 1", rd_empty); end
  endtask

  task test_overflow;
    frame({8'h41, 8'h42, 8'h30, 80'hA0A1A2A3A4A5A6A7A8A9, 8'h55}, 14);
    tests++; if (rerrcnt !== 8'd6) begin failed++; $display("FAIL ovf_first_ok: got %0d want 6", rerrcnt); end
    frame({8'h41, 8'h42, 8'h30, 80'hB0B1B2B3B4B5B6B7B8B9, 8'h55}, 14);
    tests++; if (rerrcnt !== 8'd7) begin failed++; $display("FAIL ovf_error: got %0d want 7", rerrcnt); end
    for (int i = 0; i < 10; i++) begin
      pop();
      tests++;
      if (rd_data !== 8'hA0 + 8'(i)) begin
        failed++;
        $display("FAIL ovf_readback[%0d]: got %h want %h", i, rd_data, 8'hA0 + 8'(i));
      end
    end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL ovf_drained: got %b want 1", rd_empty); end
    pop();
    tests++; if (rd_data !== 8'hA9) begin failed++; $display("FAIL rd_when_empty_data: got %h want a9", rd_data); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL rd_when_empty_flag: got %b want 1", rd_empty); end
  endtask

  task test_saturation;
    for (int i = 0; i < 247; i++) begin
      send_bytes({8'h41}, 1);
      send_eof();
    end
    tests++; if (rerrcnt !== 8'd254) begin failed++; $display("FAIL sat_254: got %0d want 254", rerrcnt); end
    for (int i = 0; i < 13; i++) begin
      send_bytes({8'h41}, 1);
      send_eof();
    end
    tests++; if (rerrcnt !== 8'd255) begin failed++; $display("FAIL sat_255: got %0d want 255", rerrcnt); end
  endtask

  task test_reset_mid_body;
    frame({8'h41, 8'h42, 8'h32, 8'hC3, 8'h55}, 5);
    tests++; if (ack_needed !== 1'b1) begin failed++; $display("FAIL rstmid_pre_ack: got %b want 1", ack_needed); end
    send_bytes({8'h41, 8'h42, 8'h30, 8'h11}, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL rstmid_rd_empty: got %b want 1", rd_empty); end
    tests++; if (rd_data !== 8'h00) begin failed++; $display("FAIL rstmid_rd_data: got %h want 00", rd_data); end
    tests++; if (ack_needed !== 1'b0) begin failed++; $display("FAIL rstmid_ack_needed: got %b want 0", ack_needed); end
    tests++; if (ack_addr !== 8'h00) begin failed++; $display("FAIL rstmid_ack_addr: got %h want 00", ack_addr); end
    tests++; if (rerrcnt !== 8'd0) begin failed++; $display("FAIL rstmid_rerrcnt: got %0d want 0", rerrcnt); end
    frame({8'h41, 8'h42, 8'h30, 8'h5A, 8'h55}, 5);
    pop();
    tests++; if (rd_data !== 8'h5A) begin failed++; $display("FAIL rstmid_next_frame: got %h want 5a", rd_data); end
    tests++; if (rd_empty !== 1'b1) begin failed++; $display("FAIL rstmid_next_len: got %b want 1", rd_empty); end
    tests++; if (rerrcnt !== 8'd0) begin failed++; $display("FAIL rstmid_next_err: got %0d want 0", rerrcnt); end
  endtask

  initial begin
    test_reset();
    test_data_noack();
    test_data_ack();
    test_bcast_and_filter();
    test_ack_rx();
    test_ack_overwrite();
    test_errors();
    test_overflow();
    test_saturation();
    test_reset_mid_body();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
